// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator (H/V sync, visible-area flag,
// pixel position, line/frame strobes) with an integer pixel-clock divider and run enable.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add the frame_cnt output and FRAME_W.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned H_SYNC_POL = 0,
  parameter int unsigned V_SYNC_POL = 0,
  parameter int unsigned PIX_DIV    = 1,
  parameter int unsigned CNT_W      = 10
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  parameter int unsigned FRAME_W    = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [FRAME_W-1:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int unsigned MAX_TOTAL    = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
  localparam int unsigned DIV_W        = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic             H_ACT    = 1'(H_SYNC_POL != 0);
  localparam logic             V_ACT    = 1'(V_SYNC_POL != 0);

  // Reject configurations whose counters cannot hold a full line or frame
  if ($clog2(MAX_TOTAL) > CNT_W) begin : g_cnt_w_too_small
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end
  if (PIX_DIV < 1) begin : g_bad_pix_div
    $error("vga_timing_gen: PIX_DIV must be at least 1");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_sync_act_c;
  logic             v_sync_act_c;
  logic             visible_c;
  logic             line_hit_c;
  logic             frame_hit_c;

  // Pixel strobe: last divider phase while running
  assign pix_en = en && (div_cnt == DIV_LAST);

  // Pixel-clock divider; holds its phase while en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Raster position counters, advanced once per pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  // Decode of the current (pre-increment) position
  assign h_sync_act_c = (32'(h_cnt) >= H_SYNC_START) && (32'(h_cnt) < H_SYNC_END);
  assign v_sync_act_c = (32'(v_cnt) >= V_SYNC_START) && (32'(v_cnt) < V_SYNC_END);
  assign visible_c    = (32'(h_cnt) < H_VISIBLE) && (32'(v_cnt) < V_VISIBLE);
  assign line_hit_c   = (h_cnt == '0);
  assign frame_hit_c  = line_hit_c && (v_cnt == '0);

  // Output register: loads the decode on each pixel, strobes last exactly one clk
  always_ff @(posedge clk) begin
    if (rst) begin
      hpos        <= '0;
      vpos        <= '0;
      hsync       <= ~H_ACT;
      vsync       <= ~V_ACT;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hpos        <= h_cnt;
      vpos        <= v_cnt;
      hsync       <= h_sync_act_c ? H_ACT : ~H_ACT;
      vsync       <= v_sync_act_c ? V_ACT : ~V_ACT;
      display_on  <= visible_c;
      line_start  <= line_hit_c;
      frame_start <= frame_hit_c;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Frames started since reset, bumped on the edge that raises frame_start
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (pix_en && frame_hit_c) begin
      frame_cnt <= frame_cnt + FRAME_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-geometry instances (PIX_DIV=1 active-low syncs,
// PIX_DIV=3 active-high syncs), directed table, hand-written corner sequences and
// randomized en/rst checked against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int unsigned HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int unsigned VV = 5, VF = 1, VS = 2, VB = 2;
  localparam int unsigned HT = HV + HF + HS + HB;
  localparam int unsigned VT = VV + VF + VS + VB;
  localparam int unsigned FP = HT * VT;
  localparam int unsigned FCNT_MOD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en  = 1'b0;

  logic       pe0, hs0, vs0, dp0, ls0, fs0;
  logic [3:0] hp0, vp0;
  logic       pe1, hs1, vs1, dp1, ls1, fs1;
  logic [4:0] hp1, vp1;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [1:0] fc0, fc1;
`endif

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(0), .V_SYNC_POL(0), .PIX_DIV(1), .CNT_W(4)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .FRAME_W(2)
`endif
  ) dut0 (
    .clk(clk), .rst(rst), .en(en), .pix_en(pe0), .hsync(hs0), .vsync(vs0),
    .display_on(dp0), .hpos(hp0), .vpos(vp0), .line_start(ls0), .frame_start(fs0)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc0)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(1), .V_SYNC_POL(1), .PIX_DIV(3), .CNT_W(5)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .FRAME_W(2)
`endif
  ) dut1 (
    .clk(clk), .rst(rst), .en(en), .pix_en(pe1), .hsync(hs1), .vsync(vs1),
    .display_on(dp1), .hpos(hp1), .vpos(vp1), .line_start(ls1), .frame_start(fs1)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc1)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 100)
        $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int hp; int vp; bit hs; bit vs; bit dp; bit ls; bit fs; int fc;
  } out_t;

  function automatic int unsigned div_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic bit pol_of(input int i);
    return (i != 0);
  endfunction

  // Outputs after ec enabled clocks since reset; lp = last edge carried a pixel
  function automatic out_t model(input int i, input int unsigned ec, input bit lp);
    out_t o;
    int unsigned k, idx, h, v;
    k = ec / div_of(i);
    if (k == 0) begin
      o = '{0, 0, !pol_of(i), !pol_of(i), 1'b0, 1'b0, 1'b0, 0};
    end else begin
      idx  = (k - 1) % FP;
      h    = idx % HT;
      v    = idx / HT;
      o.hp = int'(h);
      o.vp = int'(v);
      o.hs = (h >= HV + HF && h < HV + HF + HS) ? pol_of(i) : !pol_of(i);
      o.vs = (v >= VV + VF && v < VV + VF + VS) ? pol_of(i) : !pol_of(i);
      o.dp = (h < HV) && (v < VV);
      o.ls = lp && (h == 0);
      o.fs = lp && (idx == 0);
      o.fc = int'(((k + FP - 1) / FP) % FCNT_MOD);
    end
    return o;
  endfunction

  int unsigned en_clks [2] = '{0, 0};
  bit          last_pix[2] = '{1'b0, 1'b0};
  bit          model_on = 1'b0;

  // Track enabled-clock count per instance
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        en_clks[i]  <= 0;
        last_pix[i] <= 1'b0;
      end else if (en) begin
        last_pix[i] <= ((en_clks[i] % div_of(i)) == div_of(i) - 1);
        en_clks[i]  <= en_clks[i] + 1;
      end else begin
        last_pix[i] <= 1'b0;
      end
    end
  end

  task automatic cmp_out(input string p, input out_t a, input out_t e, input bit pe,
                         input bit pe_exp);
    chk({p, ".pix_en"}, int'(pe), int'(pe_exp));
    chk({p, ".hpos"}, a.hp, e.hp);
    chk({p, ".vpos"}, a.vp, e.vp);
    chk({p, ".hsync"}, int'(a.hs), int'(e.hs));
    chk({p, ".vsync"}, int'(a.vs), int'(e.vs));
    chk({p, ".display_on"}, int'(a.dp), int'(e.dp));
    chk({p, ".line_start"}, int'(a.ls), int'(e.ls));
    chk({p, ".frame_start"}, int'(a.fs), int'(e.fs));
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk({p, ".frame_cnt"}, a.fc, e.fc);
`endif
  endtask

  task automatic check_model();
    out_t a0, a1, e0, e1;
    bit   pex0, pex1;
    e0   = model(0, en_clks[0], last_pix[0]);
    e1   = model(1, en_clks[1], last_pix[1]);
    pex0 = en && ((en_clks[0] % div_of(0)) == div_of(0) - 1);
    pex1 = en && ((en_clks[1] % div_of(1)) == div_of(1) - 1);
    a0   = '{int'(hp0), int'(vp0), hs0, vs0, dp0, ls0, fs0, 0};
    a1   = '{int'(hp1), int'(vp1), hs1, vs1, dp1, ls1, fs1, 0};
`ifdef VGA_TIMING_FRAME_CNT_EN
    a0.fc = int'(fc0);
    a1.fc = int'(fc1);
`endif
    cmp_out("m0", a0, e0, pe0, pex0);
    cmp_out("m1", a1, e1, pe1, pex1);
  endtask

  // Continuous model comparison, sampled on the falling edge
  always @(negedge clk) if (model_on) check_model();

  // Inputs change 2 time units after a falling edge, clear of both edges
  task automatic set_in(input bit r, input bit e);
    #2;
    rst = r;
    en  = e;
  endtask

  // ---------------- directed table (dut0, PIX_DIV=1) ----------------
  typedef struct {
    bit rst; bit en; int n;
    int hp; int vp; bit hs; bit vs; bit dp; bit ls; bit fs;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int t, cnt, lcnt;

    tbl[0]  = '{1'b1, 1'b1, 2,  0,  0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1,  0,  0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1,  1,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 9,  10, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 3,  13, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 2,  0,  1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 5,  0,  1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1,  1,  1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 74, 0,  6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 30, 0,  8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 29, 14, 9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1,  0,  0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1,  0,  0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1,  0,  0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    model_on = 1'b1;

    foreach (tbl[j]) begin
      set_in(tbl[j].rst, tbl[j].en);
      repeat (tbl[j].n) @(negedge clk);
      chk($sformatf("tbl%0d.hpos", j), int'(hp0), tbl[j].hp);
      chk($sformatf("tbl%0d.vpos", j), int'(vp0), tbl[j].vp);
      chk($sformatf("tbl%0d.hsync", j), int'(hs0), int'(tbl[j].hs));
      chk($sformatf("tbl%0d.vsync", j), int'(vs0), int'(tbl[j].vs));
      chk($sformatf("tbl%0d.display_on", j), int'(dp0), int'(tbl[j].dp));
      chk($sformatf("tbl%0d.line_start", j), int'(ls0), int'(tbl[j].ls));
      chk($sformatf("tbl%0d.frame_start", j), int'(fs0), int'(tbl[j].fs));
    end

    // Freeze mid-line for 37 clks, then resume at the next pixel
    t = 0;
    while (hp0 != 4'd7 && t < 200) begin @(negedge clk); t++; end
    chk("freeze.reach_hpos", int'(hp0), 7);
    set_in(1'b0, 1'b0);
    repeat (37) begin
      @(negedge clk);
      chk("freeze.hpos_hold", int'(hp0), 7);
      chk("freeze.line_start", int'(ls0), 0);
      chk("freeze.pix_en", int'(pe0), 0);
    end
    set_in(1'b0, 1'b1);
    @(negedge clk);
    chk("freeze.resume_hpos", int'(hp0), 8);

    // PIX_DIV=3: frame period and single-clk line strobes
    t = 0;
    while (fs1 !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    chk("div3.first_frame_start", int'(fs1), 1);
    cnt = 0; lcnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (ls1) lcnt++;
    end while (fs1 !== 1'b1 && cnt < 1000);
    chk("div3.frame_period", cnt, 3 * FP);
    chk("div3.line_strobe_clks", lcnt, VT);

    // PIX_DIV=1 frame period
    t = 0;
    while (fs0 !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (fs0 !== 1'b1 && cnt < 400);
    chk("div1.frame_period", cnt, FP);

    // Reset mid-frame restarts at (0,0)
    t = 0;
    while (vp0 != 4'd3 && t < 400) begin @(negedge clk); t++; end
    chk("midrst.reach_vpos", int'(vp0), 3);
    set_in(1'b1, 1'b1);
    @(negedge clk);
    chk("midrst.hpos", int'(hp0), 0);
    chk("midrst.vpos", int'(vp0), 0);
    chk("midrst.frame_start", int'(fs0), 0);
    set_in(1'b0, 1'b1);
    @(negedge clk);
    chk("midrst.restart_frame_start", int'(fs0), 1);
    chk("midrst.restart_hpos", int'(hp0), 0);

    // Randomized en/rst against the model
    for (int c = 0; c < 3000; c++) begin
      set_in(($urandom % 400) == 0, ($urandom % 6) != 0);
      @(negedge clk);
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // frame_cnt at five successive frame starts
    set_in(1'b1, 1'b1);
    @(negedge clk);
    set_in(1'b0, 1'b1);
    for (int f = 0; f < 5; f++) begin
      t = 0;
      while (fs0 !== 1'b1 && t < 400) begin @(negedge clk); t++; end
      chk("fcnt.frame_start", int'(fs0), 1);
      chk($sformatf("fcnt.value%0d", f), int'(fc0), (f + 1) % 4);
      @(negedge clk);
    end
`endif

    model_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
